// File: rtl/store_merge_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : store_merge_unit
// Description : Sub-word store path; read-modify-write of a word-addressed
//               data memory for byte/halfword stores, direct word writes.
// Revision    : 1.0 - initial release
// ============================================================================
module store_merge_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int c_cnt_w = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(RD_LAT - 1);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_rd   = 3'd1;
    localparam logic [2:0] c_st_wait = 3'd2;
    localparam logic [2:0] c_st_wr   = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic [1:0]         r_size;
    logic               r_err;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_wdata;
    logic [31:0]        w_merged;
    logic               w_misaligned;

    assign w_misaligned = ((req_size == 2'd2) && req_addr[0]) ||
                          ((req_size == 2'd3) && (req_addr[1:0] != 2'b00));

    // Lane replacement on the returned word, little-endian lane numbering
    always_comb begin
        w_merged = mem_rdata;
        case (r_size)
            2'd1:    w_merged[{r_addr[1:0], 3'b000} +: 8]  = r_data[7:0];
            2'd2:    w_merged[{r_addr[1], 4'b0000} +: 16] = r_data[15:0];
            default: w_merged = r_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_addr  <= '0;
            r_data  <= '0;
            r_size  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_data  <= req_data;
                        r_size  <= req_size;
                        r_err   <= w_misaligned;
                        r_wdata <= req_data;
                    end
                end
                c_st_rd: r_cnt <= c_cnt_load;
                c_st_wait: begin
                    if (r_cnt == '0) begin
                        r_wdata <= w_merged;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        busy         = 1'b1;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            c_st_idle: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if ((req_size == 2'd0) || w_misaligned) begin
                        w_next_state = c_st_done;
                    end else if (req_size == 2'd3) begin
                        w_next_state = c_st_wr;
                    end else begin
                        w_next_state = c_st_rd;
                    end
                end
            end
            c_st_rd: begin
                mem_rd       = 1'b1;
                mem_addr     = {r_addr[31:2], 2'b00};
                w_next_state = c_st_wait;
            end
            c_st_wait: begin
                mem_addr = {r_addr[31:2], 2'b00};
                if (r_cnt == '0) begin
                    w_next_state = c_st_wr;
                end
            end
            c_st_wr: begin
                mem_wr       = 1'b1;
                mem_addr     = {r_addr[31:2], 2'b00};
                mem_wdata    = r_wdata;
                w_next_state = c_st_done;
            end
            c_st_done: begin
                done         = 1'b1;
                err          = r_err;
                w_next_state = c_st_idle;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = c_st_idle;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_store_merge_unit
// Description : Self-checking bench for store_merge_unit, two instances
//               (read latency 1 and 3) each with its own memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_merge_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_data  [2];
    logic [1:0]  req_size  [2];
    logic [31:0] mem_addr  [2];
    logic        mem_rd    [2];
    logic        mem_wr    [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];
    logic        done      [2];
    logic        err       [2];

    logic [31:0] mem     [2][256];
    logic [31:0] ref_mem [2][256];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        int         rcnt = -1;
        logic [7:0] ridx = '0;

        store_merge_unit #(.RD_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_addr  (req_addr[g]),
            .req_data  (req_data[g]),
            .req_size  (req_size[g]),
            .mem_addr  (mem_addr[g]),
            .mem_rd    (mem_rd[g]),
            .mem_wr    (mem_wr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .err       (err[g])
        );

        // Memory: read data valid only in the cycle LAT after the read strobe
        always @(posedge clk) begin
            int c;
            if (mem_wr[g]) mem[g][mem_addr[g][9:2]] = mem_wdata[g];
            if (mem_rd[g]) begin
                ridx = mem_addr[g][9:2];
                c = LAT - 1;
            end else if (rcnt > 0) begin
                c = rcnt - 1;
            end else begin
                c = -1;
            end
            rcnt = c;
            mem_rdata[g] <= (c == 0) ? mem[g][ridx] : $urandom();
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int i);
        int k;
        for (k = 0; k < 20 && !req_ready[i]; k++) @(negedge clk);
        if (!req_ready[i]) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Expected result of a store, from the lane rules
    function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [31:0] data, input logic [1:0] sz);
        int          sh;
        logic [31:0] mask;
        if (sz == 2'd3) return data;
        sh   = (sz == 2'd1) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
        mask = ((sz == 2'd1) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        return (old & ~mask) | ((data << sh) & mask);
    endfunction

    task automatic do_store(input int i, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] sz, input string tag,
                            output logic [31:0] wd_obs, output logic err_obs);
        int          lat;
        logic        misal, sub, wst;
        int          e_wr, e_done;
        int          rd_n, rd_cnt, wr_n, wr_cnt, done_n, conflicts;
        logic [31:0] rd_a, wr_a, exp_w, waddr;
        logic        ready_back, busy1;
        lat    = (i == 0) ? 1 : 3;
        misal  = ((sz == 2'd2) && addr[0]) || ((sz == 2'd3) && (addr[1:0] != 2'b00));
        sub    = !misal && ((sz == 2'd1) || (sz == 2'd2));
        wst    = !misal && (sz == 2'd3);
        e_wr   = sub ? 2 + lat : (wst ? 1 : 0);
        e_done = sub ? 3 + lat : (wst ? 2 : 1);
        waddr  = {addr[31:2], 2'b00};
        exp_w  = merge_ref(ref_mem[i][addr[9:2]], addr, data, sz);
        rd_n = 0; rd_cnt = 0; wr_n = 0; wr_cnt = 0; done_n = 0; conflicts = 0;
        rd_a = '0; wr_a = '0; wd_obs = '0; err_obs = 1'b0; ready_back = 1'b0; busy1 = 1'b0;

        wait_idle(i);
        req_valid[i] = 1'b1;
        req_addr[i]  = addr;
        req_data[i]  = data;
        req_size[i]  = sz;
        for (int n = 1; n <= e_done + 1; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_valid[i] = 1'b0;
                req_addr[i]  = $urandom();
                req_data[i]  = $urandom();
                req_size[i]  = 2'($urandom_range(0, 3));
                busy1        = busy[i];
            end
            if (mem_rd[i]) begin rd_cnt++; rd_n = n; rd_a = mem_addr[i]; end
            if (mem_wr[i]) begin wr_cnt++; wr_n = n; wr_a = mem_addr[i]; wd_obs = mem_wdata[i]; end
            if (done[i] && done_n == 0) begin done_n = n; err_obs = err[i]; end
            if ((done[i] || err[i]) && (mem_rd[i] || mem_wr[i])) conflicts++;
            if (err[i] && !done[i]) conflicts++;
            if (n == e_done + 1) ready_back = req_ready[i];
        end
        chk({tag, "_busy"}, 32'(busy1), 32'd1);
        chk({tag, "_rd_cnt"}, rd_cnt, sub ? 1 : 0);
        chk({tag, "_rd_cycle"}, rd_n, sub ? 1 : 0);
        if (sub) chk({tag, "_rd_addr"}, rd_a, waddr);
        chk({tag, "_wr_cnt"}, wr_cnt, (sub || wst) ? 1 : 0);
        chk({tag, "_wr_cycle"}, wr_n, e_wr);
        if (sub || wst) begin
            chk({tag, "_wr_addr"}, wr_a, waddr);
            chk({tag, "_wdata"}, wd_obs, exp_w);
            ref_mem[i][addr[9:2]] = exp_w;
        end
        chk({tag, "_done_cycle"}, done_n, e_done);
        chk({tag, "_err"}, 32'(err_obs), 32'(misal));
        chk({tag, "_overlap"}, conflicts, 0);
        chk({tag, "_ready_back"}, 32'(ready_back), 32'd1);
    endtask

    task automatic check_reset_outputs(input int i, input string tag);
        chk({tag, "_ready"}, 32'(req_ready[i]), 32'd1);
        chk({tag, "_busy"},  32'(busy[i]),      32'd0);
        chk({tag, "_rd"},    32'(mem_rd[i]),    32'd0);
        chk({tag, "_wr"},    32'(mem_wr[i]),    32'd0);
        chk({tag, "_done"},  32'(done[i]),      32'd0);
        chk({tag, "_err"},   32'(err[i]),       32'd0);
        chk({tag, "_addr"},  mem_addr[i],       32'd0);
        chk({tag, "_wdata"}, mem_wdata[i],      32'd0);
    endtask

    task automatic preset(input int i, input logic [31:0] addr, input logic [31:0] val);
        mem[i][addr[9:2]]     = val;
        ref_mem[i][addr[9:2]] = val;
    endtask

    initial begin
        logic [31:0] wd;
        logic        e;
        int          rd1, rd2, d1, d2, rdy5, wrs, bad;

        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0;
            req_addr[i] = '0; req_data[i] = '0; req_size[i] = '0;
            for (int w = 0; w < 256; w++) begin
                mem[i][w]     = $urandom();
                ref_mem[i][w] = mem[i][w];
            end
        end
        repeat (2) @(negedge clk);
        check_reset_outputs(0, "rst0");
        check_reset_outputs(1, "rst1");
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);

        // Directed cases
        preset(0, 32'h102, 32'hAABBCCDD);
        do_store(0, 32'h102, 32'h11, 2'd1, "byte", wd, e);
        chk("byte_const", wd, 32'hAA11CCDD);
        preset(0, 32'h202, 32'hAABBCCDD);
        do_store(0, 32'h202, 32'h1234, 2'd2, "half_hi", wd, e);
        chk("half_hi_const", wd, 32'h1234CCDD);
        preset(0, 32'h200, 32'hAABBCCDD);
        do_store(0, 32'h200, 32'h1234, 2'd2, "half_lo", wd, e);
        chk("half_lo_const", wd, 32'hAABB1234);
        do_store(0, 32'h300, 32'hDEADBEEF, 2'd3, "word", wd, e);
        chk("word_const", wd, 32'hDEADBEEF);
        do_store(0, 32'h201, 32'h5555, 2'd2, "mis_half", wd, e);
        chk("mis_half_err", 32'(e), 32'd1);
        do_store(0, 32'h204, 32'h5555, 2'd0, "size0", wd, e);
        chk("size0_err", 32'(e), 32'd0);
        preset(1, 32'h100, 32'hAABBCCDD);
        do_store(1, 32'h103, 32'h5A, 2'd1, "lat3_byte", wd, e);
        chk("lat3_byte_const", wd, 32'h5ABBCCDD);

        // Request held through a busy store: second accept only after done
        preset(0, 32'h140, 32'hAABBCCDD);
        wait_idle(0);
        req_valid[0] = 1'b1; req_addr[0] = 32'h141; req_data[0] = 32'h77; req_size[0] = 2'd1;
        rd1 = 0; rd2 = 0; d1 = 0; d2 = 0; rdy5 = 0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (mem_rd[0]) begin if (rd1 == 0) rd1 = n; else rd2 = n; end
            if (done[0])   begin if (d1 == 0)  d1 = n;  else d2 = n;  end
            if (n == 5) rdy5 = req_ready[0];
            if (n == 6) req_valid[0] = 1'b0;
        end
        chk("hold_rd1", rd1, 1);
        chk("hold_done1", d1, 4);
        chk("hold_ready", rdy5, 1);
        chk("hold_rd2", rd2, 6);
        chk("hold_done2", d2, 9);
        ref_mem[0][8'h50] = 32'hAABB77DD;

        // Reset during the read wait abandons the store
        wait_idle(1);
        req_valid[1] = 1'b1; req_addr[1] = 32'h180; req_data[1] = 32'h99; req_size[1] = 2'd1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", 32'(busy[1]), 32'd1);
        rst_n[1] = 1'b0;
        #1;
        check_reset_outputs(1, "rstmid");
        @(negedge clk);
        rst_n[1] = 1'b1;
        wrs = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (mem_wr[1]) wrs++;
        end
        chk("rstmid_no_wr", wrs, 0);

        // Randomized stores on both instances
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 40; t++) begin
                logic [31:0] a;
                a = $urandom();
                if ($urandom_range(0, 3) != 0) a[1:0] = (a[1:0] & 2'($urandom_range(0, 3)));
                do_store(i, a, $urandom(), 2'($urandom_range(0, 3)), $sformatf("rnd%0d_%0d", i, t), wd, e);
            end
        end

        for (int i = 0; i < 2; i++) begin
            bad = 0;
            for (int w = 0; w < 256; w++) if (mem[i][w] !== ref_mem[i][w]) bad++;
            chk($sformatf("mem_sweep%0d", i), bad, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
